// File: rtl/ahb_lite_master.sv
// AHB-Lite bus master: turns one command into a SINGLE/INCRx burst.
// Address and data phases overlap; write beats stall with BUSY.
module ahb_lite_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    hclk,
  input  logic                    hresetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [2:0]              cmd_size,
  input  logic [2:0]              cmd_burst,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic                    wdata_valid,
  output logic                    wdata_ready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    rdata_valid,
  output logic                    done,
  output logic                    done_err,
  output logic [ADDR_WIDTH-1:0]   haddr,
  output logic [1:0]              htrans,
  output logic                    hwrite,
  output logic [2:0]              hsize,
  output logic [2:0]              hburst,
  output logic [3:0]              hprot,
  output logic [DATA_WIDTH-1:0]   hwdata,
  output logic [DATA_WIDTH/8-1:0] hwstrb,
  input  logic                    hready,
  input  logic                    hresp,
  input  logic [DATA_WIDTH-1:0]   hrdata
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int LB = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_ERR
  } state_t;

  state_t                  state;
  logic                    a_pend;
  logic                    first;
  logic                    d_pend;
  logic                    d_wr;
  logic [3:0]              a_rem;
  logic [3:0]              beats_m1;
  logic                    act;
  logic                    acc;
  logic [NB-1:0]           strb;
  logic [ADDR_WIDTH-1:0]   incr;
  logic [LB-1:0]           boff;

  assign act  = (state == S_ADDR) || (state == S_DATA);
  assign acc  = htrans[1] && hready;
  assign incr = ADDR_WIDTH'(1) << hsize;
  assign boff = haddr[LB-1:0];

  assign wdata_ready = acc && hwrite;

  // A write beat is only presented while its data is on wdata
  always_comb begin
    htrans = 2'b00;
    if (act && a_pend) begin
      if (hwrite && !wdata_valid)
        htrans = first ? 2'b00 : 2'b01;
      else
        htrans = first ? 2'b10 : 2'b11;
    end
  end

  always_comb begin
    beats_m1 = 4'd0;
    case (cmd_burst)
      3'b011:  beats_m1 = 4'd3;
      3'b101:  beats_m1 = 4'd7;
      3'b111:  beats_m1 = 4'd15;
      default: beats_m1 = 4'd0;
    endcase
  end

  always_comb begin
    strb = '0;
    for (int i = 0; i < NB; i++)
      strb[i] = (i >= int'(boff)) &&
                ((i - int'(boff)) < (1 << hsize));
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state       <= S_IDLE;
      cmd_ready   <= 1'b0;
      haddr       <= '0;
      hwrite      <= 1'b0;
      hsize       <= '0;
      hburst      <= '0;
      hprot       <= '0;
      hwdata      <= '0;
      hwstrb      <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      done        <= 1'b0;
      done_err    <= 1'b0;
      a_pend      <= 1'b0;
      first       <= 1'b0;
      d_pend      <= 1'b0;
      d_wr        <= 1'b0;
      a_rem       <= '0;
    end else begin
      rdata_valid <= 1'b0;
      done        <= 1'b0;
      done_err    <= 1'b0;
      case (state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            state     <= S_ADDR;
            haddr     <= cmd_addr;
            hwrite    <= cmd_write;
            hsize     <= cmd_size;
            hburst    <= cmd_burst;
            hprot     <= 4'b0011;
            a_rem     <= beats_m1;
            a_pend    <= 1'b1;
            first     <= 1'b1;
            d_pend    <= 1'b0;
          end
        end
        S_ADDR, S_DATA: begin
          if (d_pend && !hready && hresp) begin
            state  <= S_ERR;
            a_pend <= 1'b0;
          end else if (hready) begin
            if (d_pend && !d_wr && !hresp) begin
              rdata       <= hrdata;
              rdata_valid <= 1'b1;
            end
            if (acc) begin
              state  <= S_DATA;
              d_pend <= 1'b1;
              d_wr   <= hwrite;
              hwstrb <= hwrite ? strb : '0;
              if (hwrite)
                hwdata <= wdata;
              if (a_rem != 4'd0) begin
                haddr <= haddr + incr;
                a_rem <= a_rem - 4'd1;
                first <= 1'b0;
              end else begin
                a_pend <= 1'b0;
              end
            end else begin
              d_pend <= 1'b0;
              hwstrb <= '0;
              if (!a_pend) begin
                state     <= S_IDLE;
                done      <= 1'b1;
                cmd_ready <= 1'b1;
              end else begin
                state <= S_ADDR;
              end
            end
          end
        end
        S_ERR: begin
          if (hready) begin
            state     <= S_IDLE;
            done      <= 1'b1;
            done_err  <= 1'b1;
            cmd_ready <= 1'b1;
            d_pend    <= 1'b0;
            hwstrb    <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
